// File: rtl/coprocessor0_if.sv
// Write-back to CP0 bus type and the CP0 port bundle: the WB side drives the
// commit bus, interrupt lines and fault address; CP0 returns read data and redirect state.
package coprocessor0_params;
  typedef struct packed {
    logic [4:0]  address_register;
    logic [2:0]  address_select;
    logic        write_enabled;
    logic [31:0] write_data;
    logic        exception_valid;
    logic [31:0] exception_address;
    logic        eret_flush;
    logic        in_delay_slot;
    logic [4:0]  exception_code;
  } WBToCP0Data;
endpackage

interface coprocessor0_if;
  import coprocessor0_params::*;

  WBToCP0Data  wb_to_cp0_data_bus;
  logic [31:0] bad_virtual_address;
  logic [5:0]  hardware_interrupt;
  logic [31:0] cp0_read_data;
  logic [31:0] exception_program_count;
  logic [31:0] exception_entry;
  logic        interrupt_pending;

  modport master (
    output wb_to_cp0_data_bus, bad_virtual_address, hardware_interrupt,
    input  cp0_read_data, exception_program_count, exception_entry, interrupt_pending
  );

  modport slave (
    input  wb_to_cp0_data_bus, bad_virtual_address, hardware_interrupt,
    output cp0_read_data, exception_program_count, exception_entry, interrupt_pending
  );
endinterface

// File: rtl/coprocessor0.sv
// MIPS CP0: BadVAddr, Status, Cause, EPC, plus Count/Compare timer when CP0_TIMER_EN is defined.
// Commits MTC0/exception/ERET from write-back and serves MFC0 reads combinationally.
module coprocessor0 #(
  parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380
) (
  input logic              clock,
  input logic              reset,
  coprocessor0_if.slave    bus
);
  import coprocessor0_params::*;

  localparam logic [7:0] AddrBadVAddr = {5'd8, 3'd0};
  localparam logic [7:0] AddrCount    = {5'd9, 3'd0};
  localparam logic [7:0] AddrCompare  = {5'd11, 3'd0};
  localparam logic [7:0] AddrStatus   = {5'd12, 3'd0};
  localparam logic [7:0] AddrCause    = {5'd13, 3'd0};
  localparam logic [7:0] AddrEpc      = {5'd14, 3'd0};

  WBToCP0Data wb;
  logic [7:0] addr;
  logic       exc;
  logic       mtc0;
  logic       eret;

  assign wb   = bus.wb_to_cp0_data_bus;
  assign addr = {wb.address_register, wb.address_select};
  assign exc  = wb.exception_valid;
  assign mtc0 = wb.write_enabled & ~exc;
  assign eret = wb.eret_flush & ~exc;

  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic        ti;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;
  logic        count_wr, compare_wr;

  assign ti         = ti_q;
  assign count_wr   = mtc0 && (addr == AddrCount);
  assign compare_wr = mtc0 && (addr == AddrCompare);

  always_comb begin
    tick_d    = ~tick_q;
    compare_d = compare_wr ? wb.write_data : compare_q;
    // A Count write takes precedence over the half-rate increment.
    if (count_wr)    count_d = wb.write_data;
    else if (tick_q) count_d = count_q + 32'd1;
    else             count_d = count_q;
    if (compare_wr)                  ti_d = 1'b0;
    else if (count_q == compare_q)   ti_d = 1'b1;
    else                             ti_d = ti_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    bad_vaddr_d = bad_vaddr_q;
    epc_d       = epc_q;
    im_d        = im_q;
    exl_d       = exl_q;
    ie_d        = ie_q;
    bd_d        = bd_q;
    exc_code_d  = exc_code_q;
    ip_sw_d     = ip_sw_q;
    ip_hw_d     = {bus.hardware_interrupt[5] | ti, bus.hardware_interrupt[4:0]};
    if (exc) begin
      exc_code_d = wb.exception_code;
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = wb.in_delay_slot ? wb.exception_address - 32'd4 : wb.exception_address;
        bd_d  = wb.in_delay_slot;
      end
      exl_d = 1'b1;
      if (wb.exception_code == 5'd4 || wb.exception_code == 5'd5) begin
        bad_vaddr_d = bus.bad_virtual_address;
      end
    end else begin
      if (eret) exl_d = 1'b0;
      // Applied after ERET so an MTC0 to Status.EXL in the same cycle wins.
      if (mtc0) begin
        case (addr)
          AddrStatus: begin
            im_d  = wb.write_data[15:8];
            exl_d = wb.write_data[1];
            ie_d  = wb.write_data[0];
          end
          AddrCause: ip_sw_d = wb.write_data[9:8];
          AddrEpc:   epc_d   = wb.write_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bad_vaddr_q <= '0;
      epc_q       <= '0;
      im_q        <= '0;
      exl_q       <= 1'b0;
      ie_q        <= 1'b0;
      bd_q        <= 1'b0;
      exc_code_q  <= '0;
      ip_hw_q     <= '0;
      ip_sw_q     <= '0;
    end else begin
      bad_vaddr_q <= bad_vaddr_d;
      epc_q       <= epc_d;
      im_q        <= im_d;
      exl_q       <= exl_d;
      ie_q        <= ie_d;
      bd_q        <= bd_d;
      exc_code_q  <= exc_code_d;
      ip_hw_q     <= ip_hw_d;
      ip_sw_q     <= ip_sw_d;
    end
  end

  logic [31:0] status_word;
  logic [31:0] cause_word;

  assign status_word = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_word  = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    bus.cp0_read_data = '0;
    case (addr)
      AddrBadVAddr: bus.cp0_read_data = bad_vaddr_q;
`ifdef CP0_TIMER_EN
      AddrCount:    bus.cp0_read_data = count_q;
      AddrCompare:  bus.cp0_read_data = compare_q;
`endif
      AddrStatus:   bus.cp0_read_data = status_word;
      AddrCause:    bus.cp0_read_data = cause_word;
      AddrEpc:      bus.cp0_read_data = epc_q;
      default:      bus.cp0_read_data = '0;
    endcase
  end

  assign bus.exception_program_count = epc_q;
  assign bus.exception_entry         = EXCEPTION_ENTRY;
  assign bus.interrupt_pending       = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_coprocessor0.sv
// Self-checking bench for coprocessor0: directed scenarios then random traffic,
// every cycle compared against a register-level behavioural model.
module tb_coprocessor0;
  import coprocessor0_params::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  coprocessor0_if bus ();

  WBToCP0Data  drv;
  logic [31:0] bva;
  logic [5:0]  hw;

  assign bus.wb_to_cp0_data_bus  = drv;
  assign bus.bad_virtual_address = bva;
  assign bus.hardware_interrupt  = hw;

  coprocessor0 #(.EXCEPTION_ENTRY(32'hBFC0_0380)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
  bit          m_tick, m_ti;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic [2:0] s);
    if (s != 3'd0) return 32'h0;
    case (r)
      5'd8:  return m_bad;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      5'd12: return m_status;
      5'd13: return {m_cause[31], m_ti, m_cause[29:0]};
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_pending();
    logic [31:0] c;
    c = model_read(5'd13, 3'd0);
    return (|(c[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
  endfunction

  task automatic model_clock();
    logic [31:0] n_status, n_cause, n_epc, n_bad, n_count, n_compare;
    bit          n_ti, cnt_wr, cmp_wr;
    if (!reset) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
      m_count = 0; m_compare = 0; m_tick = 0; m_ti = 0;
      return;
    end
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
    n_count = m_count; n_compare = m_compare; n_ti = m_ti;
    cnt_wr = 0; cmp_wr = 0;
    if (drv.exception_valid) begin
      n_cause[6:2] = drv.exception_code;
      if (!m_status[1]) begin
        n_epc = drv.in_delay_slot ? drv.exception_address - 4 : drv.exception_address;
        n_cause[31] = drv.in_delay_slot;
      end
      n_status[1] = 1'b1;
      if (drv.exception_code == 4 || drv.exception_code == 5) n_bad = bva;
    end else begin
      if (drv.eret_flush) n_status[1] = 1'b0;
      if (drv.write_enabled && drv.address_select == 0) begin
        case (drv.address_register)
          5'd12: n_status = (n_status & ~32'h0000_FF03) | (drv.write_data & 32'h0000_FF03);
          5'd13: n_cause  = (n_cause & ~32'h0000_0300) | (drv.write_data & 32'h0000_0300);
          5'd14: n_epc    = drv.write_data;
`ifdef CP0_TIMER_EN
          5'd9:  begin n_count = drv.write_data; cnt_wr = 1; end
          5'd11: begin n_compare = drv.write_data; cmp_wr = 1; end
`endif
          default: ;
        endcase
      end
    end
`ifdef CP0_TIMER_EN
    if (!cnt_wr && m_tick) n_count = m_count + 1;
    n_ti = cmp_wr ? 1'b0 : (m_count == m_compare) ? 1'b1 : m_ti;
    m_tick = !m_tick;
`endif
    n_cause[15:10] = {hw[5] | m_ti, hw[4:0]};
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    m_count = n_count; m_compare = n_compare; m_ti = n_ti;
  endtask

  // Called just after the negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check("read_data", bus.cp0_read_data,
          model_read(drv.address_register, drv.address_select));
    check("pending", {31'b0, bus.interrupt_pending}, {31'b0, model_pending()});
    check("epc_out", bus.exception_program_count, m_epc);
    check("entry", bus.exception_entry, 32'hBFC0_0380);
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic idle_bus();
    drv.write_enabled = 0; drv.exception_valid = 0; drv.eret_flush = 0;
  endtask

  task automatic peek(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
    idle_bus();
    drv.address_register = r; drv.address_select = s;
    #1 v = bus.cp0_read_data;
    cycle();
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    idle_bus();
    drv.address_register = r; drv.address_select = 0;
    drv.write_enabled = 1; drv.write_data = d;
    cycle();
    idle_bus();
  endtask

  task automatic raise(input logic [31:0] ea, input bit ids, input logic [4:0] code,
                       input logic [31:0] fault);
    idle_bus();
    drv.exception_valid = 1; drv.exception_address = ea;
    drv.in_delay_slot = ids; drv.exception_code = code; bva = fault;
    cycle();
    idle_bus();
  endtask

  logic [31:0] v;

  initial begin
    drv = '0; bva = 0; hw = 0; reset = 0;
    @(negedge clock);
    @(posedge clock);
    model_clock();
    @(negedge clock);
    reset = 1;

    // Reset state
    peek(5'd12, 3'd0, v); check("reset_status", v, 32'h0040_0000);
    peek(5'd13, 3'd0, v); check("reset_cause", v, 32'h0);
    check("reset_pending", {31'b0, bus.interrupt_pending}, 32'h0);

    // Exception in delay slot with AdEL
    raise(32'hBFC0_1000, 1, 5'd4, 32'h0000_0003);
    peek(5'd14, 3'd0, v); check("exc_epc", v, 32'hBFC0_0FFC);
    peek(5'd13, 3'd0, v); check("exc_bd_code", v & 32'h8000_007C, 32'h8000_0010);
    peek(5'd8, 3'd0, v);  check("exc_badvaddr", v, 32'h0000_0003);
    peek(5'd12, 3'd0, v); check("exc_exl", v, 32'h0040_0002);
    raise(32'h8000_0000, 0, 5'd0, 32'hDEAD_BEEF);
    peek(5'd14, 3'd0, v); check("nested_epc", v, 32'hBFC0_0FFC);
    peek(5'd8, 3'd0, v);  check("nested_badvaddr", v, 32'h0000_0003);

    // Interrupt enable
    hw = 6'b000100;
    mtc0(5'd12, 32'h0000_FF01);
    #1 check("irq_pending", {31'b0, bus.interrupt_pending}, 32'h1);
    raise(32'h0000_0100, 0, 5'd0, 32'h0);
    peek(5'd12, 3'd0, v); check("exl_set", v, 32'h0040_FF03);
    idle_bus(); drv.eret_flush = 1; cycle(); idle_bus();
    peek(5'd12, 3'd0, v); check("eret_exl", v, 32'h0040_FF01);

    // Exception beats simultaneous MTC0 to EPC
    idle_bus();
    drv.exception_valid = 1; drv.exception_address = 32'h0000_2000;
    drv.in_delay_slot = 0; drv.exception_code = 5'd8;
    drv.write_enabled = 1; drv.address_register = 5'd14; drv.address_select = 0;
    drv.write_data = 32'h0000_1234;
    cycle(); idle_bus();
    peek(5'd14, 3'd0, v); check("exc_beats_mtc0", v, 32'h0000_2000);

`ifdef CP0_TIMER_EN
    hw = 0;
    mtc0(5'd9, 32'hFFFF_FFFE);
    mtc0(5'd11, 32'h0);
    repeat (8) cycle();
    peek(5'd13, 3'd0, v);
    check("ti_set", {31'b0, v[30]}, 32'h1);
    check("ip7_from_ti", {31'b0, v[15]}, 32'h1);
    mtc0(5'd11, 32'h1000_0000);
    peek(5'd13, 3'd0, v); check("ti_cleared", {31'b0, v[30]}, 32'h0);
`else
    mtc0(5'd9, 32'h1234_5678);
    mtc0(5'd11, 32'h0);
    repeat (100) cycle();
    peek(5'd9, 3'd0, v);  check("no_timer_count", v, 32'h0);
    peek(5'd11, 3'd0, v); check("no_timer_compare", v, 32'h0);
    peek(5'd13, 3'd0, v); check("no_timer_ti", {31'b0, v[30]}, 32'h0);
`endif

    // Reset mid-operation
    hw = 6'b000100;
    mtc0(5'd12, 32'h0000_FF01);
    #1 check("pre_reset_pending", {31'b0, bus.interrupt_pending}, 32'h1);
    reset = 0; cycle(); reset = 1;
    #1 check("post_reset_pending", {31'b0, bus.interrupt_pending}, 32'h0);
    peek(5'd12, 3'd0, v); check("post_reset_status", v, 32'h0040_0000);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [4:0] regs [8];
      int k;
      regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd12};
      k = $urandom_range(0, 7);
      drv.address_register = regs[k];
      drv.address_select   = (k == 7) ? 3'd1 : 3'd0;
      drv.write_enabled    = ($urandom_range(0, 2) == 0);
      drv.write_data       = $urandom;
      if (drv.address_register == 5'd9 && $urandom_range(0, 1) == 1)
        drv.write_data = m_compare - $urandom_range(0, 8);
      drv.exception_valid   = ($urandom_range(0, 9) == 0);
      drv.exception_address = $urandom;
      drv.in_delay_slot     = $urandom_range(0, 1);
      drv.exception_code    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5))
                                                          : 5'($urandom);
      drv.eret_flush        = ($urandom_range(0, 7) == 0);
      bva = $urandom;
      if ($urandom_range(0, 7) == 0) hw = 6'($urandom);
      reset = ($urandom_range(0, 99) != 0);
      cycle();
    end
    reset = 1;
    idle_bus();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
